// File: rtl/ifm_win_pkg.sv
// Shared constants and types for the IFM 3x3 window generator.
// Tile geometry, derived window counts, counter widths and the FSM state type.
package ifm_win_pkg;

    localparam int DATA_W   = 16;
    localparam int ROWS     = 4;
    localparam int COLS     = 11;
    localparam int K        = 3;

    localparam int WIN_ROWS = ROWS - K + 1;
    localparam int WIN_COLS = COLS - K + 1;

    localparam int ROW_W    = (WIN_ROWS > 1) ? $clog2(WIN_ROWS) : 1;
    localparam int COL_W    = (WIN_COLS > 1) ? $clog2(WIN_COLS) : 1;

    localparam int TILE_W   = DATA_W * ROWS * COLS;
    localparam int WIN_W    = DATA_W * K * K;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        STREAM
    } state_t;

endpackage

// File: rtl/ifm_win_mux.sv
// Combinational 3x3 window extraction from a packed IFM tile.
// Tile word (r,c) sits at DATA_W*(ROWS*c + ROWS-1-r); window element (kr,kc)
// is placed at DATA_W*(K*kr + kc) and equals tile(row+kr, col+kc).
module ifm_win_mux
    import ifm_win_pkg::*;
(
    input  logic [TILE_W-1:0] tile,
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    output logic [WIN_W-1:0]  win
);

    localparam int IDX_W = $clog2(TILE_W);

    for (genvar kr = 0; kr < K; kr++) begin : g_kr
        for (genvar kc = 0; kc < K; kc++) begin : g_kc
            logic [IDX_W-1:0] base;

            // Bit offset of tile(row+kr, col+kc) within the packed tile.
            assign base = IDX_W'(DATA_W * (ROWS * (int'(col) + kc) + ROWS - 1 - (int'(row) + kr)));
            assign win[DATA_W*(K*kr+kc) +: DATA_W] = tile[base +: DATA_W];
        end
    end

endmodule

// File: rtl/ifm_window_gen.sv
// IFM window generator: captures a 4x11 tile from the IFM register controller,
// releases the controller buffer with a one-cycle height_hs pulse, then streams
// the 18 overlapping 3x3 windows row-major over a valid/ready interface.
// Optional feature macro: IFM_WIN_PREFETCH_EN adds a shadow tile register so the
// next tile is fetched during the current stream and tiles follow with no gap.
module ifm_window_gen
    import ifm_win_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [TILE_W-1:0] tile_data,
    input  logic              tile_valid,
    output logic              height_hs,
    output logic [WIN_W-1:0]  win_data,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [ROW_W-1:0]  win_row,
    output logic [COL_W-1:0]  win_col,
    output logic              win_last
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(WIN_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIN_COLS - 1);

    state_t            state;
    logic [TILE_W-1:0] tile_q;
    logic              fire;
    logic              at_last;

`ifdef IFM_WIN_PREFETCH_EN
    logic [TILE_W-1:0] shadow_q;
    logic              shadow_full;
`endif

    assign fire     = win_valid & win_ready;
    assign at_last  = (win_row == LAST_ROW) && (win_col == LAST_COL);
    assign win_last = win_valid & at_last;

    ifm_win_mux u_mux (
        .tile (tile_q),
        .row  (win_row),
        .col  (win_col),
        .win  (win_data)
    );

    // FSM, window counters, tile register(s) and registered handshake outputs.
    // NOTE: every state element here uses <= so all updates land together at the
    // edge; reads in this block always see the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            height_hs <= 1'b0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            // NOTE: the tile register is a wide datapath store that would normally
            // be left unreset; it is cleared here so win_data reads zero out of reset.
            tile_q    <= '0;
`ifdef IFM_WIN_PREFETCH_EN
            shadow_q    <= '0;
            shadow_full <= 1'b0;
`endif
        end else begin
            height_hs <= 1'b0;
            case (state)
                IDLE: begin
                    win_valid <= 1'b0;
                    if (tile_valid) begin
                        tile_q    <= tile_data;
                        win_row   <= '0;
                        win_col   <= '0;
                        height_hs <= 1'b1;
                        state     <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    win_valid <= 1'b1;
                    state     <= STREAM;
                end

                STREAM: begin
                    if (fire) begin
                        if (at_last) begin
                            win_row <= '0;
                            win_col <= '0;
`ifdef IFM_WIN_PREFETCH_EN
                            if (shadow_full) begin
                                tile_q      <= shadow_q;
                                shadow_full <= 1'b0;
                            end else begin
                                win_valid <= 1'b0;
                                state     <= IDLE;
                            end
`else
                            win_valid <= 1'b0;
                            state     <= IDLE;
`endif
                        end else if (win_col == LAST_COL) begin
                            win_col <= '0;
                            win_row <= win_row + 1'b1;
                        end else begin
                            win_col <= win_col + 1'b1;
                        end
                    end
`ifdef IFM_WIN_PREFETCH_EN
                    // A tile arriving on the last-window handshake with an empty
                    // shadow is left for IDLE to capture, so it is never dropped.
                    if (tile_valid && !shadow_full && !height_hs && !(fire && at_last)) begin
                        shadow_q    <= tile_data;
                        shadow_full <= 1'b1;
                        height_hs   <= 1'b1;
                    end
`endif
                end

                default: begin
                    win_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifm_window_gen.sv
// Scoreboard bench for ifm_window_gen: stimulus pushes the expected windows of
// every tile it offers; a negedge monitor pops and compares each accepted window,
// checks stall stability and height_hs pulse width.
module tb_ifm_window_gen;
    import ifm_win_pkg::*;

    typedef struct {
        logic [WIN_W-1:0] data;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic             last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [TILE_W-1:0] tile_data = '0;
    logic              tile_valid = 1'b0;
    logic              height_hs;
    logic [WIN_W-1:0]  win_data;
    logic              win_valid;
    logic              win_ready = 1'b1;
    logic [ROW_W-1:0]  win_row;
    logic [COL_W-1:0]  win_col;
    logic              win_last;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   hs_cyc[$];
    int   acc_cyc[$];

    ifm_window_gen dut (
        .clk        (clk),
        .rst        (rst),
        .tile_data  (tile_data),
        .tile_valid (tile_valid),
        .height_hs  (height_hs),
        .win_data   (win_data),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_row    (win_row),
        .win_col    (win_col),
        .win_last   (win_last)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Tile word (r,c): 16'h0r0c for seed 0, upper byte xored with the seed.
    function automatic logic [DATA_W-1:0] pat(input logic [7:0] seed, input int r, input int c);
        return {4'h0, 4'(r), 4'h0, 4'(c)} ^ {seed, 8'h00};
    endfunction

    function automatic logic [TILE_W-1:0] build_tile(input logic [7:0] seed);
        logic [TILE_W-1:0] t = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                t[DATA_W*(ROWS*c + ROWS-1-r) +: DATA_W] = pat(seed, r, c);
        return t;
    endfunction

    task automatic push_tile(input logic [7:0] seed);
        exp_t e;
        for (int r = 0; r < WIN_ROWS; r++) begin
            for (int c = 0; c < WIN_COLS; c++) begin
                e.data = '0;
                for (int kr = 0; kr < K; kr++)
                    for (int kc = 0; kc < K; kc++)
                        e.data[DATA_W*(K*kr+kc) +: DATA_W] = pat(seed, r+kr, c+kc);
                e.row  = ROW_W'(r);
                e.col  = COL_W'(c);
                e.last = (r == WIN_ROWS-1) && (c == WIN_COLS-1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input string name);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (height_hs) break;
        end
        check(name, WIN_W'(height_hs), WIN_W'(1));
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400; i++) begin
            tick();
            if (exp_q.size() == 0 && !win_valid) break;
        end
        check(name, WIN_W'(exp_q.size()), WIN_W'(0));
    endtask

    task automatic check_outputs_idle(input string name);
        check({name, "_win_valid"}, WIN_W'(win_valid), WIN_W'(0));
        check({name, "_height_hs"}, WIN_W'(height_hs), WIN_W'(0));
        check({name, "_win_last"},  WIN_W'(win_last),  WIN_W'(0));
        check({name, "_win_row"},   WIN_W'(win_row),   WIN_W'(0));
        check({name, "_win_col"},   WIN_W'(win_col),   WIN_W'(0));
        check({name, "_win_data"},  win_data,          WIN_W'(0));
    endtask

    // Monitor: scoreboard pops, stall-hold stability and height_hs pulse width.
    initial begin
        logic             prev_hs = 1'b0;
        logic             held_valid = 1'b0;
        logic [WIN_W-1:0] held_data = '0;
        logic [ROW_W-1:0] held_row = '0;
        logic [COL_W-1:0] held_col = '0;
        logic             held_last = 1'b0;
        exp_t             e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hs    = 1'b0;
                held_valid = 1'b0;
            end else begin
                if (height_hs) begin
                    check("height_hs_one_cycle", WIN_W'(prev_hs), WIN_W'(0));
                    hs_cyc.push_back(cyc);
                end
                if (held_valid && win_valid) begin
                    check("hold_data", win_data, held_data);
                    check("hold_row", WIN_W'(win_row), WIN_W'(held_row));
                    check("hold_col", WIN_W'(win_col), WIN_W'(held_col));
                    check("hold_last", WIN_W'(win_last), WIN_W'(held_last));
                end
                if (win_valid && win_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL spurious_window: got row %0d col %0d, expected no window", win_row, win_col);
                    end else begin
                        e = exp_q.pop_front();
                        check("win_data", win_data, e.data);
                        check("win_row", WIN_W'(win_row), WIN_W'(e.row));
                        check("win_col", WIN_W'(win_col), WIN_W'(e.col));
                        check("win_last", WIN_W'(win_last), WIN_W'(e.last));
                        acc_cyc.push_back(cyc);
                    end
                end
                prev_hs    = height_hs;
                held_valid = win_valid && !win_ready;
                held_data  = win_data;
                held_row   = win_row;
                held_col   = win_col;
                held_last  = win_last;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held 3 cycles with tile_valid high: nothing may start.
        tile_data  = build_tile(8'h00);
        tile_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_win_valid", WIN_W'(win_valid), WIN_W'(0));
            check("rst_height_hs", WIN_W'(height_hs), WIN_W'(0));
        end

        // Single tile, word(r,c) = 16'h0r0c, no backpressure.
        hs_cyc.delete();
        acc_cyc.delete();
        push_tile(8'h00);
        rst = 1'b0;
        check_outputs_idle("post_rst");
        tick();
        check("t1_hs_latency", WIN_W'(height_hs), WIN_W'(1));
        check("t1_valid_in_capture", WIN_W'(win_valid), WIN_W'(0));
        tile_valid = 1'b0;
        tick();
        check("t1_first_valid", WIN_W'(win_valid), WIN_W'(1));
        check("t1_hs_low", WIN_W'(height_hs), WIN_W'(0));
        check("t1_w0_e00", WIN_W'(win_data[15:0]), WIN_W'(16'h0000));
        check("t1_w0_e11", WIN_W'(win_data[79:64]), WIN_W'(16'h0101));
        wait_drain("t1_drain");
        check("t1_accepted", WIN_W'(acc_cyc.size()), WIN_W'(18));
        check("t1_hs_count", WIN_W'(hs_cyc.size()), WIN_W'(1));
        if (acc_cyc.size() == 18)
            check("t1_back_to_back", WIN_W'(acc_cyc[17] - acc_cyc[0]), WIN_W'(17));

        // Backpressure: win_ready toggles every cycle.
        hs_cyc.delete();
        acc_cyc.delete();
        win_ready  = 1'b0;
        tile_data  = build_tile(8'h10);
        tile_valid = 1'b1;
        push_tile(8'h10);
        tick();
        tile_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            win_ready = ~win_ready;
            if (exp_q.size() == 0 && !win_valid) break;
        end
        check("t2_drain", WIN_W'(exp_q.size()), WIN_W'(0));
        check("t2_accepted", WIN_W'(acc_cyc.size()), WIN_W'(18));
        check("t2_hs_count", WIN_W'(hs_cyc.size()), WIN_W'(1));
        win_ready = 1'b1;
        tick();

        // tile_valid held high across two distinct tiles.
        hs_cyc.delete();
        acc_cyc.delete();
        tile_data  = build_tile(8'h11);
        tile_valid = 1'b1;
        push_tile(8'h11);
        wait_hs("t3_hs0");
        tile_data = build_tile(8'h22);
        push_tile(8'h22);
        wait_hs("t3_hs1");
        tile_valid = 1'b0;
        wait_drain("t3_drain");
        check("t3_accepted", WIN_W'(acc_cyc.size()), WIN_W'(36));
        check("t3_hs_count", WIN_W'(hs_cyc.size()), WIN_W'(2));
        if (acc_cyc.size() == 36 && hs_cyc.size() == 2) begin
            check("t3_first_latency", WIN_W'(acc_cyc[0] - hs_cyc[0]), WIN_W'(1));
            check("t3_tile0_span", WIN_W'(acc_cyc[17] - acc_cyc[0]), WIN_W'(17));
            check("t3_tile1_span", WIN_W'(acc_cyc[35] - acc_cyc[18]), WIN_W'(17));
`ifdef IFM_WIN_PREFETCH_EN
            check("t3_no_bubble", WIN_W'(acc_cyc[18] - acc_cyc[17]), WIN_W'(1));
            check("t3_hs1_in_stream", WIN_W'(hs_cyc[1] < acc_cyc[17]), WIN_W'(1));
`else
            check("t3_gap", WIN_W'(acc_cyc[18] - acc_cyc[17]), WIN_W'(3));
            check("t3_hs1_after_idle", WIN_W'(hs_cyc[1] - acc_cyc[17]), WIN_W'(2));
`endif
        end
        tick();

        // Reset after 5 accepted windows, then a fresh tile.
        hs_cyc.delete();
        acc_cyc.delete();
        tile_data  = build_tile(8'h20);
        tile_valid = 1'b1;
        push_tile(8'h20);
        tick();
        tile_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (acc_cyc.size() >= 5) break;
        end
        check("t4_accepted_before_rst", WIN_W'(acc_cyc.size()), WIN_W'(5));
        rst = 1'b1;
        exp_q.delete();
        tick();
        check("t4_valid_after_rst", WIN_W'(win_valid), WIN_W'(0));
        hs_cyc.delete();
        acc_cyc.delete();
        tile_data  = build_tile(8'h30);
        tile_valid = 1'b1;
        push_tile(8'h30);
        rst = 1'b0;
        check_outputs_idle("t4_post_rst");
        tick();
        tile_valid = 1'b0;
        wait_drain("t4_drain");
        check("t4_accepted", WIN_W'(acc_cyc.size()), WIN_W'(18));
        check("t4_hs_count", WIN_W'(hs_cyc.size()), WIN_W'(1));

        // tile_valid re-asserted with new data only during CAPTURE: ignored.
        hs_cyc.delete();
        acc_cyc.delete();
        tile_data  = build_tile(8'h40);
        tile_valid = 1'b1;
        push_tile(8'h40);
        tick();
        check("t5_hs", WIN_W'(height_hs), WIN_W'(1));
        tile_data = build_tile(8'h50);
        tick();
        tile_valid = 1'b0;
        wait_drain("t5_drain");
        for (int i = 0; i < 4; i++) tick();
        check("t5_accepted", WIN_W'(acc_cyc.size()), WIN_W'(18));
        check("t5_hs_count", WIN_W'(hs_cyc.size()), WIN_W'(1));
        check("t5_idle_valid", WIN_W'(win_valid), WIN_W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifm_window_gen.md
# ifm_window_gen

Downstream stage of the IFM register controller. It captures one 4-row × 11-column tile of 16-bit IFM words when the controller flags it valid, then returns a one-cycle release pulse on the controller's height handshake input. It then streams all 18 overlapping 3×3 windows, row-major, to the PE array over a valid/ready interface.

## Interface
Parameters:
- DATA_W, 16, bits per IFM word
- ROWS, 4, tile rows
- COLS, 11, tile columns
- K, 3, window size; WIN_ROWS = ROWS-K+1 = 2, WIN_COLS = COLS-K+1 = 9

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset: one clock, synchronous, active-high
- tile_data  in  DATA_W*ROWS*COLS (704)  tile words; row r, column c at bit offset DATA_W*(ROWS*c + ROWS-1-r)
- tile_valid  in  1  level; the controller's tile buffer is full
- height_hs  out  1  registered one-cycle pulse; the tile is taken, advance to the next buffer
- win_data  out  DATA_W*K*K (144)  window element (kr,kc) at bit offset DATA_W*(K*kr+kc) = tile(row+kr, col+kc)
- win_valid  out  1  window valid
- win_ready  in  1  consumer accepts
- win_row  out  1  window row index, 0..1
- win_col  out  4  window column index, 0..8
- win_last  out  1  high with the window at row 1, column 8

## Operation
- FSM states: IDLE, CAPTURE, STREAM.
- IDLE, tile_valid=1: load tile_data into the active tile register, clear row/col, go to CAPTURE.
- CAPTURE (1 cycle): height_hs=1, win_valid=0, go to STREAM.
- STREAM: win_valid=1. win_data is extracted combinationally from the active register at (win_row, win_col).
- On a handshake (win_valid & win_ready):
  - col < 8: col+1.
  - col = 8: col=0, row+1.
  - At (1,8), which is the last window: go to IDLE.
- No capture is ever taken in the cycle height_hs is high. In that cycle the controller's valid still reflects the released buffer.
- tile_valid is ignored in CAPTURE. In STREAM it is ignored unless IFM_WIN_PREFETCH_EN is defined.
- Counters wrap only through the last-window transition. No index outside 0..1 / 0..8 is ever presented.
- Reset at any time, including mid-stream: state goes to IDLE and the in-flight tile is dropped. There is no release pulse for it.

## Timing
- Values while rst is asserted and on the first cycle after release:
  - win_valid=0, height_hs=0, win_last=0
  - win_row=0, win_col=0, win_data=0
  - tile registers cleared
- Latency:
  - tile_valid sampled in IDLE at cycle t.
  - height_hs high in cycle t+1.
  - First window valid in cycle t+2.
- Hold rule: while win_valid & !win_ready, win_data, win_row, win_col and win_last are held stable.
- Throughput: with no backpressure, 18 windows in 18 consecutive cycles. Without prefetch, minimum 20 cycles per tile.

## Configuration
- IFM_WIN_PREFETCH_EN defined:
  - Adds a shadow tile register and a shadow_full flag.
  - In STREAM, if tile_valid & !shadow_full & !height_hs, load the shadow register and pulse height_hs next cycle.
  - On the last-window handshake with shadow_full=1: copy the shadow into the active register, clear shadow_full and row/col, and stay in STREAM. There are zero bubble cycles between tiles.
  - Reset also clears shadow_full.
- Undefined: single tile register and behaviour exactly as in Operation.

## Structure
- Package ifm_win_pkg holds:
  - DATA_W, ROWS, COLS, K
  - Derived WIN_ROWS, WIN_COLS and the counter widths
  - The FSM state typedef (IDLE, CAPTURE, STREAM)
- One sub-module, ifm_win_mux: purely combinational 3×3 extraction from a tile vector, given the row/col indices.
- The FSM, counters, tile registers and handshake live in the top module.

## Test plan
- Reset: hold rst for 3 cycles with tile_valid=1 -> win_valid=0 and height_hs=0 throughout. The first pulse comes only after rst deasserts.
- Single tile, word(r,c) = 16'h0r0c, win_ready=1:
  - height_hs high for exactly one cycle.
  - 18 windows in order. Window 0 element (0,0) = 16'h0000. Window 17 element (1,1) = 16'h0209.
  - win_last only on window 17.
- Backpressure, win_ready toggled every other cycle -> each window held stable while stalled. Exactly 18 distinct windows, no duplicates or skips.
- tile_valid held high, two distinct tiles:
  - Without the macro: one height_hs per 18 windows and a 2-cycle gap between tiles.
  - With IFM_WIN_PREFETCH_EN: 36 windows in 36 consecutive cycles, and the second height_hs occurs during the first tile's stream.
- Reset after 5 accepted windows -> win_valid low the next cycle. After release, a new tile starts at row 0, col 0.
- tile_valid pulsed during CAPTURE only -> no capture, no extra height_hs.
